// File: rtl/alu_seq.sv
// Bit-serial ALU sequencer: feeds one operand bit per cycle (LSB first) to an
// external 1-bit ALU slice and assembles the WIDTH-bit result, carry and zero flag.
module alu_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_carry_in,
  output logic [2:0]       slice_select,
  input  logic             slice_out,
  input  logic             slice_carry_out,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic            rdy_q;
  logic            vld_q;
  logic [IW-1:0]   idx_q;
  logic [2:0]      op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic            cry_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic            zero_q;
  logic            arith;
  logic            last;

  assign arith = (op_q == OP_SUB) || (op_q == OP_ADD);
  assign last  = (idx_q == IW'(WIDTH - 1));

  always_comb begin
    res_d = res_q;
    if (state_q == RUN) res_d[idx_q] = slice_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cry_q   <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            cry_q   <= ((op == OP_SUB) || (op == OP_ADD)) ? cin : 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            rdy_q   <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q <= res_d;
          cry_q <= arith ? slice_carry_out : 1'b0;
          // zero is captured from the completed result so it stays stable in DONE
          if (last) begin
            zero_q  <= (res_d == '0);
            vld_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (result_ready) begin
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign slice_a        = (state_q == RUN) ? a_q[idx_q] : 1'b0;
  assign slice_b        = (state_q == RUN) ? b_q[idx_q] : 1'b0;
  assign slice_carry_in = (state_q == RUN) ? cry_q : 1'b0;
  assign slice_select   = (state_q == RUN) ? op_q : 3'd0;

  assign start_ready  = rdy_q;
  assign result_valid = vld_q;
  assign result       = res_q;
  assign carry        = cry_q;
  assign zero         = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with a reference 1-bit ALU slice attached.
module tb_alu_seq;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst, start_valid, start_ready, cin;
  logic [2:0] op;
  logic [W-1:0] a, b, result;
  logic slice_a, slice_b, slice_carry_in, slice_out, slice_carry_out;
  logic [2:0] slice_select;
  logic carry, zero, result_valid, result_ready;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .a(a), .b(b), .cin(cin),
    .slice_a(slice_a), .slice_b(slice_b), .slice_carry_in(slice_carry_in),
    .slice_select(slice_select), .slice_out(slice_out), .slice_carry_out(slice_carry_out),
    .result(result), .carry(carry), .zero(zero),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  // Reference 1-bit ALU slice
  always_comb begin
    slice_out       = 1'b0;
    slice_carry_out = 1'b0;
    case (slice_select)
      3'd0: slice_out = ~(slice_a ^ slice_b);
      3'd1: slice_out = slice_a;
      3'd2: begin
        slice_out       = slice_a ^ slice_b ^ slice_carry_in;
        slice_carry_out = (~slice_a & slice_b) | (~(slice_a ^ slice_b) & slice_carry_in);
      end
      3'd3: begin
        slice_out       = slice_a ^ slice_b ^ slice_carry_in;
        slice_carry_out = (slice_a & slice_b) | ((slice_a ^ slice_b) & slice_carry_in);
      end
      3'd4: slice_out = slice_a ^ slice_b;
      3'd5: slice_out = slice_a | slice_b;
      3'd6: slice_out = ~slice_a;
      default: slice_out = slice_a & slice_b;
    endcase
  end

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    string        name;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;
  bit rr_rand = 0;
  bit b2b = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Whole-word reference: plain arithmetic, no bit-serial stepping
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input string nm);
    exp_t e;
    logic [W:0] t;
    e.c = 1'b0;
    e.name = nm;
    case (o)
      3'd0: e.res = ~(x ^ y);
      3'd1: e.res = x;
      3'd2: begin t = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, ci}; e.res = t[W-1:0]; e.c = t[W]; end
      3'd3: begin t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci}; e.res = t[W-1:0]; e.c = t[W]; end
      3'd4: e.res = x ^ y;
      3'd5: e.res = x | y;
      3'd6: e.res = ~x;
      default: e.res = x & y;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Monitor: sampled mid-cycle, after stimulus settles on the falling edge
  int cyc = 0, acc_cyc = 0;
  bit b2b_seen = 0;
  logic prev_sr = 1'bx, prev_rv = 1'bx;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (prev_sr === 1'b1 && start_ready === 1'b0) begin
        if (b2b && b2b_seen) check("b2b_spacing", 16'(cyc - acc_cyc), 16'(W + 2));
        b2b_seen = b2b;
        acc_cyc  = cyc;
      end
      if (prev_rv !== 1'b1 && result_valid === 1'b1)
        check("latency", 16'(cyc - acc_cyc), 16'(W));
      if (result_valid === 1'b1 && result_ready === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_result: got %0h with empty scoreboard", result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_res"}, 16'(result), 16'(e.res));
          check({e.name, "_carry"}, 16'(carry), 16'(e.c));
          check({e.name, "_zero"}, 16'(zero), 16'(e.z));
        end
      end
      prev_sr = start_ready;
      prev_rv = result_valid;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rr_rand) result_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input string nm, input bit hold);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (start_ready !== 1'b1 && n < 64);
    if (start_ready !== 1'b1) begin
      check({nm, "_ready_timeout"}, 16'(start_ready), 16'd1);
      return;
    end
    start_valid = 1'b1; op = o; a = x; b = y; cin = ci;
    sb.push_back(model(o, x, y, ci, nm));
    @(negedge clk);
    if (!hold) start_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (result_valid !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (result_valid !== 1'b1) check({nm, "_valid_timeout"}, 16'(result_valid), 16'd1);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_start_ready"}, 16'(start_ready), 16'd1);
    check({nm, "_result_valid"}, 16'(result_valid), 16'd0);
    check({nm, "_result"}, 16'(result), 16'd0);
    check({nm, "_carry"}, 16'(carry), 16'd0);
    check({nm, "_zero"}, 16'(zero), 16'd0);
    check({nm, "_slice"}, 16'({slice_a, slice_b, slice_carry_in, slice_select}), 16'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int n;
    rst = 1'b1; start_valid = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0; result_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed cases
    issue(3'd3, 4'h9, 4'h8, 1'b0, "add_9_8", 0);
    issue(3'd2, 4'h3, 4'h5, 1'b0, "sub_3_5", 0);
    issue(3'd2, 4'h5, 4'h5, 1'b0, "sub_5_5", 0);
    issue(3'd7, 4'hC, 4'hA, 1'b1, "and_c_a", 0);
    issue(3'd0, 4'h6, 4'h6, 1'b0, "test_6_6", 0);
    issue(3'd6, 4'h3, 4'h0, 1'b0, "not_3", 0);
    issue(3'd1, 4'h5, 4'hF, 1'b1, "pass_cin1", 0);
    issue(3'd2, 4'h8, 4'h3, 1'b1, "sub_bin1", 0);

    // Backpressure in DONE
    issue(3'd3, 4'hA, 4'h7, 1'b1, "bp", 0);
    result_ready = 1'b0;
    e = model(3'd3, 4'hA, 4'h7, 1'b1, "bp");
    wait_valid("bp");
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", 16'(result_valid), 16'd1);
      check("bp_hold_ready", 16'(start_ready), 16'd0);
      check("bp_hold_res", 16'(result), 16'(e.res));
      check("bp_hold_carry", 16'(carry), 16'(e.c));
      check("bp_hold_zero", 16'(zero), 16'(e.z));
      check("bp_hold_slice", 16'({slice_a, slice_b, slice_carry_in, slice_select}), 16'd0);
      start_valid = 1'b1; op = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
      @(negedge clk);
    end
    check("bp_after_res", 16'(result), 16'(e.res));
    start_valid = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 16'(start_ready), 16'd1);
    check("bp_release_valid", 16'(result_valid), 16'd0);

    // Reset in the middle of an ADD (7+6+1), at bit index 2
    issue(3'd3, 4'h7, 4'h6, 1'b1, "aborted", 0);
    @(negedge clk);
    @(negedge clk);
    check("mid_slice_a", 16'(slice_a), 16'd1);
    check("mid_slice_cin", 16'(slice_carry_in), 16'd1);
    check("mid_slice_sel", 16'(slice_select), 16'd3);
    rst = 1'b1;
    start_valid = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    void'(sb.pop_back());
    check_reset_outputs("midrst");
    rst = 1'b0;
    start_valid = 1'b0;
    issue(3'd3, 4'h1, 4'h1, 1'b0, "add_after_rst", 0);

    // Back-to-back with valid and ready held high
    wait_valid("pre_b2b");
    b2b = 1'b1;
    for (int i = 0; i < 6; i++)
      issue(3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), "b2b", 1);
    wait_valid("b2b_last");
    start_valid = 1'b0;
    @(negedge clk);
    b2b = 1'b0;

    // Random operations with random result backpressure
    rr_rand = 1'b1;
    for (int i = 0; i < 40; i++)
      issue(3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), "rand", 0);
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rr_rand = 1'b0;
    result_ready = 1'b1;
    check("drain_empty", 16'(sb.size()), 16'd0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning operand/result width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port start_valid, input, 1, request operation.
REQ-005 SHALL have port start_ready, output, 1, block can accept request.
REQ-006 SHALL have port op, input, 3, opcode: 0 TEST (XNOR), 1 PASS_A, 2 SUB, 3 ADD, 4 XOR, 5 OR, 6 NOT_A, 7 AND.
REQ-007 SHALL have ports a and b, input, WIDTH, operands.
REQ-008 SHALL have port cin, input, 1, carry-in (ADD) or borrow-in (SUB).
REQ-009 SHALL have ports slice_a, slice_b, slice_carry_in, output, 1 each, bit operands and carry to the 1-bit ALU slice.
REQ-010 SHALL have port slice_select, output, 3, opcode to the slice.
REQ-011 SHALL have ports slice_out, slice_carry_out, input, 1 each, slice result and carry/borrow.
REQ-012 SHALL have port result, output, WIDTH, assembled result.
REQ-013 SHALL have ports carry and zero, output, 1 each, final carry/borrow and result==0 flag.
REQ-014 SHALL have port result_valid, output, 1, result available.
REQ-015 SHALL have port result_ready, input, 1, consumer accepts result.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; start_ready=1 only in IDLE; result_valid=1 only in DONE.
REQ-017 SHALL, in IDLE with start_valid=1, latch op, a, b, set carry register to cin for ADD/SUB and 0 otherwise, clear bit index to 0, clear result, enter RUN; start_valid in RUN/DONE SHALL be ignored.
REQ-018 SHALL, in RUN, drive slice_a=a_lat[idx], slice_b=b_lat[idx], slice_carry_in=carry register, slice_select=op_lat combinationally from registered state, LSB first.
REQ-019 SHALL, each RUN cycle, write slice_out into result[idx], load carry register from slice_carry_out for ADD/SUB only (forced 0 for other ops), increment idx.
REQ-020 SHALL leave RUN after the cycle with idx=WIDTH-1; result_valid SHALL assert exactly WIDTH cycles after the accepting edge.
REQ-021 SHALL hold result, carry, zero stable throughout DONE; zero SHALL equal (result==0).
REQ-022 SHALL, in DONE with result_ready=1, return to IDLE on that edge; a new request is accepted no earlier than the following edge (throughput one op per WIDTH+2 cycles with ready held high).
REQ-023 SHALL drive all slice_* outputs to 0 in IDLE and DONE.
REQ-024 SHALL not wrap idx past WIDTH-1; idx width SHALL be clog2(WIDTH) bits.
REQ-025 SHALL treat result_ready outside DONE as don't-care.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, in any state including mid-RUN, enter IDLE and clear idx, latched operands, carry register, result, carry, zero-source to 0; start_ready=1 and result_valid=0 from the cycle after reset.
REQ-027 SHALL give rst priority over start_valid and result_ready on the same edge.

Verification (bench connects a reference 1-bit ALU slice to slice_* ports, WIDTH=4)
REQ-028 SHALL check ADD a=4'h9 b=4'h8 cin=0 -> result 4'h1, carry 1, zero 0, result_valid 4 cycles after accept.
REQ-029 SHALL check SUB a=4'h3 b=4'h5 cin=0 -> result 4'hE, carry (borrow) 1; SUB a=4'h5 b=4'h5 -> result 4'h0, carry 0, zero 1.
REQ-030 SHALL check AND a=4'hC b=4'hA -> 4'h8, carry 0; TEST a=b=4'h6 -> 4'hF; NOT_A a=4'h3 -> 4'hC; PASS_A with cin=1 -> carry 0.
REQ-031 SHALL check backpressure: result_ready low 3 cycles in DONE -> result/carry/zero unchanged, start_ready 0, start_valid pulses ignored; release -> IDLE next cycle.
REQ-032 SHALL check reset asserted at idx=2 of an ADD -> next cycle IDLE, all outputs 0, start_ready 1; a following ADD 4'h1+4'h1 -> 4'h2, carry 0.
REQ-033 SHALL check back-to-back requests with start_valid and result_ready held high -> accepts spaced WIDTH+2 cycles, every result correct.
